mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 single-bit multiplexer.
// Each grant has a bounded tenure. Select lines change only when a new owner is granted.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       preempt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWN   = 1'b1;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [0:0] state_r, state_s;
  logic [3:0] grant_r, grant_s;
  logic [1:0] sel_r, sel_s;
  logic [1:0] last_r, last_s;
  logic [7:0] hold_r, hold_s;
  logic       busy_r;
  logic       preempt_r, preempt_s;
  logic [1:0] start_s;
  logic [2:0] pick_s;

  // The first candidate at or after start, wrapping mod 4; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest offset down so the nearest candidate wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state, grant and tenure decisions.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    sel_s     = sel_r;
    last_s    = last_r;
    hold_s    = hold_r;
    preempt_s = 1'b0;
    start_s   = last_r + 2'd1;
    pick_s    = 3'b000;
    case (state_r)
      ST_IDLE: begin
        pick_s = rr_pick(req, start_s);
        if (pick_s[2]) begin
          state_s = ST_OWN;
          grant_s = onehot(pick_s[1:0]);
          sel_s   = pick_s[1:0];
          last_s  = pick_s[1:0];
          hold_s  = 8'd0;
        end else begin
          grant_s = 4'b0000;
        end
      end
      ST_OWN: begin
        if (req[last_r]) begin
          if (hold_r < HOLD_LIM) begin
            hold_s = hold_r + 8'd1;
          end else begin
            // Tenure exhausted: rotate only if someone else is waiting.
            pick_s = rr_pick(req & ~onehot(last_r), start_s);
            if (pick_s[2]) begin
              grant_s   = onehot(pick_s[1:0]);
              sel_s     = pick_s[1:0];
              last_s    = pick_s[1:0];
              hold_s    = 8'd0;
              preempt_s = 1'b1;
            end else begin
              hold_s = HOLD_LIM;
            end
          end
        end else begin
          // The owner's request is low, so it naturally sorts last in the search.
          pick_s = rr_pick(req, start_s);
          if (pick_s[2]) begin
            grant_s = onehot(pick_s[1:0]);
            sel_s   = pick_s[1:0];
            last_s  = pick_s[1:0];
            hold_s  = 8'd0;
          end else begin
            state_s = ST_IDLE;
            grant_s = 4'b0000;
            hold_s  = 8'd0;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 4'b0000;
        hold_s  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 4'b0000;
      sel_r     <= 2'b00;
      last_r    <= 2'd3;
      hold_r    <= 8'd0;
      busy_r    <= 1'b0;
      preempt_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      sel_r     <= sel_s;
      last_r    <= last_s;
      hold_r    <= hold_s;
      busy_r    <= |grant_s;
      preempt_r <= preempt_s;
    end
  end

  assign grant   = grant_r;
  assign s0      = sel_r[0];
  assign s1      = sel_r[1];
  assign busy    = busy_r;
  assign preempt = preempt_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter using three instances, with MAX_HOLD set to 8, 4 and 1.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req8 = 4'b0000, req4 = 4'b0000, req1 = 4'b0000;
  logic [3:0] grant8, grant4, grant1;
  logic       s0_8, s1_8, busy8, pre8;
  logic       s0_4, s1_4, busy4, pre4;
  logic       s0_1, s1_1, busy1, pre1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .grant(grant8),
    .s0(s0_8), .s1(s1_8), .busy(busy8), .preempt(pre8));

  mux_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .grant(grant4),
    .s0(s0_4), .s1(s1_4), .busy(busy4), .preempt(pre4));

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .grant(grant1),
    .s0(s0_1), .s1(s1_1), .busy(busy1), .preempt(pre1));

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req8 = 4'b0000; req4 = 4'b0000; req1 = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;

    // Reset with all requests high, then release.
    rst = 1'b1; req8 = 4'b1111;
    tick(); tick();
    check_val("rst_grant", {4'b0, grant8}, 8'h00);
    check_val("rst_sel", {6'b0, s1_8, s0_8}, 8'h00);
    check_val("rst_busy", {7'b0, busy8}, 8'h00);
    check_val("rst_preempt", {7'b0, pre8}, 8'h00);
    rst = 1'b0;
    tick();
    check_val("first_grant", {4'b0, grant8}, 8'h01);
    check_val("first_sel", {6'b0, s1_8, s0_8}, 8'h00);
    check_val("first_busy", {7'b0, busy8}, 8'h01);

    // Single requester 2 for five cycles, then release.
    do_reset();
    req8 = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val("single_grant", {4'b0, grant8}, 8'h04);
      check_val("single_sel", {6'b0, s1_8, s0_8}, 8'h02);
    end
    req8 = 4'b0000;
    tick();
    check_val("single_idle_grant", {4'b0, grant8}, 8'h00);
    check_val("single_idle_busy", {7'b0, busy8}, 8'h00);
    check_val("single_idle_sel", {6'b0, s1_8, s0_8}, 8'h02);

    // Round robin: each owner drops its request after two granted cycles.
    do_reset();
    req8 = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      check_val("rr_grant_a", {4'b0, grant8}, {4'b0, exp_g});
      check_val("rr_busy", {7'b0, busy8}, 8'h01);
      req8 = 4'b1111;
      tick();
      check_val("rr_grant_b", {4'b0, grant8}, {4'b0, exp_g});
      check_val("rr_preempt", {7'b0, pre8}, 8'h00);
      req8 = 4'b1111 & ~exp_g;
      tick();
    end

    // Forced rotation: MAX_HOLD=4 swaps every 4 cycles; MAX_HOLD=1 every cycle.
    do_reset();
    req4 = 4'b0011; req1 = 4'b0011;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_val("pre4_grant", {4'b0, grant4}, (((c - 1) / 4) % 2 == 1) ? 8'h02 : 8'h01);
      check_val("pre4_sel", {6'b0, s1_4, s0_4}, (((c - 1) / 4) % 2 == 1) ? 8'h01 : 8'h00);
      check_val("pre4_pulse", {7'b0, pre4}, (c == 5 || c == 9) ? 8'h01 : 8'h00);
      check_val("pre1_grant", {4'b0, grant1}, (c % 2 == 1) ? 8'h01 : 8'h02);
      check_val("pre1_pulse", {7'b0, pre1}, (c >= 2) ? 8'h01 : 8'h00);
    end

    // No contention: tenure limit never forces rotation.
    do_reset();
    req4 = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("nocont_grant", {4'b0, grant4}, 8'h08);
      check_val("nocont_preempt", {7'b0, pre4}, 8'h00);
    end

    // Reset during the third cycle of a tenure.
    do_reset();
    req8 = 4'b0010;
    tick(); tick(); tick();
    check_val("midrst_owner", {4'b0, grant8}, 8'h02);
    req8 = 4'b0110;
    rst = 1'b1;
    tick();
    check_val("midrst_grant", {4'b0, grant8}, 8'h00);
    check_val("midrst_sel", {6'b0, s1_8, s0_8}, 8'h00);
    check_val("midrst_busy", {7'b0, busy8}, 8'h00);
    rst = 1'b0;
    tick();
    check_val("midrst_regrant", {4'b0, grant8}, 8'h02);
    check_val("midrst_resel", {6'b0, s1_8, s0_8}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
